// File: rtl/seg_dyn_driver_if.sv
// Value/format bundle from a data source to the seven-segment driver,
// plus the multiplexed digit-select and segment lines it produces.
interface seg_dyn_driver_if;
    logic [19:0] data;
    logic [5:0]  point;
    logic        sign;
    logic        seg_en;
    logic [5:0]  sel;
    logic [7:0]  seg;

    modport master (
        output data, point, sign, seg_en,
        input  sel, seg
    );

    modport slave (
        input  data, point, sign, seg_en,
        output sel, seg
    );
endinterface

// File: rtl/seg_dyn_driver.sv
// Binary-to-BCD (sequential double dabble) plus 6-digit common-anode
// seven-segment scanner with leading-zero blanking, sign and decimal points.
module seg_dyn_driver #(
    parameter int unsigned CNT_SCAN_MAX = 49_999,
    parameter int unsigned DATA_MAX     = 999_999
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    seg_dyn_driver_if.slave   bus
);

    localparam int unsigned CW = (CNT_SCAN_MAX > 0) ? $clog2(CNT_SCAN_MAX + 1) : 1;
    localparam logic [CW-1:0] CNT_MAX_C = CW'(CNT_SCAN_MAX);
    localparam logic [19:0]   SAT_C     = 20'(DATA_MAX);
    localparam logic [4:0]    LAST_SH_C = 5'd19;

    typedef enum logic [1:0] {
        S_LOAD,
        S_SHIFT,
        S_DONE
    } state_e;

    state_e state_q, state_d;

    logic [19:0]      bin_q, bin_d;
    logic [23:0]      bcd_q, bcd_d;
    logic [23:0]      bcd_adj;
    logic [4:0]       sh_cnt_q, sh_cnt_d;
    logic [5:0]       lpt_q, lpt_d;
    logic             lsign_q, lsign_d;
    logic             len_q, len_d;

    logic [5:0][3:0]  dig_q, dig_d;
    logic [5:0]       dpt_q, dpt_d;
    logic             dsign_q, dsign_d;
    logic             den_q, den_d;

    logic [CW-1:0]    cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic             wrap;

    logic [2:0]       top;
    logic [5:0]       sel_q, sel_d;
    logic [7:0]       seg_q, seg_d;

    function automatic logic [7:0] seg_code(input logic [3:0] d);
        logic [7:0] c;
        c = 8'hFF;
        unique case (d)
            4'd0:    c = 8'hC0;
            4'd1:    c = 8'hF9;
            4'd2:    c = 8'hA4;
            4'd3:    c = 8'hB0;
            4'd4:    c = 8'h99;
            4'd5:    c = 8'h92;
            4'd6:    c = 8'h82;
            4'd7:    c = 8'hF8;
            4'd8:    c = 8'h80;
            4'd9:    c = 8'h90;
            default: c = 8'hFF;
        endcase
        return c;
    endfunction

    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < 6; i++) begin
            if (bcd_q[i*4 +: 4] >= 4'd5) begin
                bcd_adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        bin_d    = bin_q;
        bcd_d    = bcd_q;
        sh_cnt_d = sh_cnt_q;
        lpt_d    = lpt_q;
        lsign_d  = lsign_q;
        len_d    = len_q;
        dig_d    = dig_q;
        dpt_d    = dpt_q;
        dsign_d  = dsign_q;
        den_d    = den_q;
        unique case (state_q)
            S_LOAD: begin
                bin_d    = (bus.data > SAT_C) ? SAT_C : bus.data;
                bcd_d    = '0;
                sh_cnt_d = '0;
                lpt_d    = bus.point;
                lsign_d  = bus.sign;
                len_d    = bus.seg_en;
                state_d  = S_SHIFT;
            end
            S_SHIFT: begin
                {bcd_d, bin_d} = {bcd_adj, bin_q} << 1;
                sh_cnt_d = sh_cnt_q + 5'd1;
                if (sh_cnt_q == LAST_SH_C) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                dig_d   = bcd_q;
                dpt_d   = lpt_q;
                dsign_d = lsign_q;
                den_d   = len_q;
                state_d = S_LOAD;
            end
            default: begin
                state_d = S_LOAD;
            end
        endcase
    end

    always_comb begin
        wrap  = (cnt_q == CNT_MAX_C);
        cnt_d = wrap ? '0 : cnt_q + 1'b1;
        idx_d = idx_q;
        if (wrap) begin
            idx_d = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
        end
    end

    // Highest digit that must be drawn; everything above it is blank
    always_comb begin
        top = 3'd0;
        for (int i = 1; i < 6; i++) begin
            if (dig_q[i] != 4'd0 || dpt_q[i]) begin
                top = 3'(i);
            end
        end
    end

    always_comb begin
        sel_d = 6'b000000;
        seg_d = 8'hFF;
        if (den_q) begin
            sel_d = 6'b000001 << idx_q;
            if (idx_q <= top) begin
                seg_d = seg_code(dig_q[idx_q]);
                if (dpt_q[idx_q]) begin
                    seg_d[7] = 1'b0;
                end
            end else if (dsign_q && idx_q == top + 3'd1) begin
                seg_d = 8'hBF;
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state_q  <= S_LOAD;
            bin_q    <= '0;
            bcd_q    <= '0;
            sh_cnt_q <= '0;
            lpt_q    <= '0;
            lsign_q  <= 1'b0;
            len_q    <= 1'b0;
            dig_q    <= '0;
            dpt_q    <= '0;
            dsign_q  <= 1'b0;
            den_q    <= 1'b0;
            cnt_q    <= '0;
            idx_q    <= '0;
            sel_q    <= 6'b000000;
            seg_q    <= 8'hFF;
        end else begin
            state_q  <= state_d;
            bin_q    <= bin_d;
            bcd_q    <= bcd_d;
            sh_cnt_q <= sh_cnt_d;
            lpt_q    <= lpt_d;
            lsign_q  <= lsign_d;
            len_q    <= len_d;
            dig_q    <= dig_d;
            dpt_q    <= dpt_d;
            dsign_q  <= dsign_d;
            den_q    <= den_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            sel_q    <= sel_d;
            seg_q    <= seg_d;
        end
    end

    assign bus.sel = sel_q;
    assign bus.seg = seg_q;

endmodule
